// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and default timing for key_debounce
package key_pkg;

  localparam logic [1:0] STABLE_HIGH = 2'd0;
  localparam logic [1:0] FILTER_DOWN = 2'd1;
  localparam logic [1:0] STABLE_LOW  = 2'd2;
  localparam logic [1:0] FILTER_UP   = 2'd3;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_LONG_CYCLES     = 50000000;
  localparam int DEF_CNT_W           = 26;

  typedef enum logic [1:0] {
    S_HIGH  = STABLE_HIGH,
    S_FDOWN = FILTER_DOWN,
    S_LOW   = STABLE_LOW,
    S_FUP   = FILTER_UP
  } key_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
    end else begin
      r_sync1 <= i_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_q = r_sync2;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key debouncer with level and press/release strobes
// Optional long-press strobe is built only when LONG_PRESS_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_key_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_press
);

  localparam logic [CNT_W-1:0] LP_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_key_sync;
  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_press;
  logic             w_press_nxt;
  logic             r_release;
  logic             w_release_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_key),
    .o_q     (w_key_sync)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_HIGH;
      r_cnt     <= '0;
      r_level   <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Any opposite sample in a filter state drops back with the count cleared.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_HIGH: begin
        if (!w_key_sync) begin
          w_state_nxt = S_FDOWN;
          w_cnt_nxt   = '0;
        end
      end
      S_FDOWN: begin
        if (w_key_sync) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_DEB_LAST) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LOW: begin
        if (w_key_sync) begin
          w_state_nxt = S_FUP;
          w_cnt_nxt   = '0;
        end
      end
      S_FUP: begin
        if (!w_key_sync) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_DEB_LAST) begin
          w_state_nxt   = S_HIGH;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b1;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_HIGH;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_key_level     = r_level;
  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LP_LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] r_lcnt;
  logic             r_long;
  logic             r_long_done;

  // lcnt only restarts on an accepted press; FILTER_UP bounces merely pause it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lcnt      <= '0;
      r_long      <= 1'b0;
      r_long_done <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (r_state == S_FDOWN && w_state_nxt == S_LOW) begin
        r_lcnt      <= '0;
        r_long_done <= 1'b0;
      end else if (r_state == S_LOW) begin
        if (r_lcnt != LP_LONG_LAST) begin
          r_lcnt <= r_lcnt + 1'b1;
        end else if (!r_long_done) begin
          r_long      <= 1'b1;
          r_long_done <= 1'b1;
        end
      end
    end
  end

  assign o_long_press = r_long;
`else
  assign o_long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed vector bench for key_debounce
module tb_key_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int CW   = 4;
`ifdef LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  // expected vector bits: {level, press, release, long}
  localparam logic [3:0] E_HI    = 4'b1000;
  localparam logic [3:0] E_PRESS = 4'b0100;
  localparam logic [3:0] E_LOW   = 4'b0000;
  localparam logic [3:0] E_REL   = 4'b1010;
  localparam logic [3:0] E_LONG  = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b1;
  logic o_key_level;
  logic o_press_pulse;
  logic o_release_pulse;
  logic o_long_press;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       key;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .CNT_W          (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_key          (key),
    .o_key_level    (o_key_level),
    .o_press_pulse  (o_press_pulse),
    .o_release_pulse(o_release_pulse),
    .o_long_press   (o_long_press)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {o_key_level, o_press_pulse, o_release_pulse, o_long_press};
  endfunction

  task automatic chk(input string name, input logic [3:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (level,press,release,long) at %0t",
               name, outs(), exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic k, input logic [3:0] e, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{k, e});
  endtask

  // k = edges since the press was accepted (acceptance edge is k = 0)
  function automatic logic [3:0] long_exp(input int k);
    return (LP_EN && k == LONG) ? E_LONG : E_LOW;
  endfunction

  initial begin
    // reset held with key pressed
    rst_n = 1'b0;
    key   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", E_HI);
    end
    key   = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_exit", E_HI);
    end

    // reset in FILTER_DOWN, then full latency from scratch
    key = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("filter_down_level", E_HI);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_filter", E_HI);
    tick();
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("relaunch_press", (e == 6) ? E_PRESS : (e == 7) ? E_LOW : E_HI);
    end

    // asynchronous reset while pressed, no clock edge involved
    #2 rst_n = 1'b0;
    #1 chk("reset_async_low", E_HI);
    key = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_exit2", E_HI);
    end

    // long hold after acceptance
    key = 1'b0;
    for (int e = 0; e < 7; e++) begin
      tick();
      chk("long_accept", (e == 6) ? E_PRESS : E_HI);
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk($sformatf("long_press_k%0d", k), long_exp(k));
    end
    key = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("long_release", (e == 6) ? E_REL : (e == 7) ? E_HI : E_LOW);
    end

    // bounce rejection: low 3, high 1, low 3, high
    push(1'b0, E_HI, 3);
    push(1'b1, E_HI, 1);
    push(1'b0, E_HI, 3);
    push(1'b1, E_HI, 4);
    // clean press, accepted at edge 6
    push(1'b0, E_HI, 6);
    push(1'b0, E_PRESS, 1);
    push(1'b0, E_LOW, 3);
    // clean release
    push(1'b1, E_LOW, 6);
    push(1'b1, E_REL, 1);
    push(1'b1, E_HI, 2);
    // bouncy press (toggle 5) then low 8, then high 8
    push(1'b0, E_HI, 1);
    push(1'b1, E_HI, 1);
    push(1'b0, E_HI, 1);
    push(1'b1, E_HI, 1);
    push(1'b0, E_HI, 6);
    push(1'b0, E_PRESS, 1);
    push(1'b0, E_LOW, 2);
    push(1'b1, E_LOW, 6);
    push(1'b1, E_REL, 1);
    push(1'b1, E_HI, 1);
    // press, then release immediately followed by re-press
    push(1'b0, E_HI, 6);
    push(1'b0, E_PRESS, 1);
    push(1'b0, E_LOW, 1);
    push(1'b1, E_LOW, 6);
    push(1'b0, E_REL, 1);
    push(1'b0, E_HI, 5);
    push(1'b0, E_PRESS, 1);
    push(1'b0, E_LOW, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      key = vecs[i].key;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
